// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   Branch resolution and squash controller. Decoded branch info (ctl, imm, pc)
//   travels down a DEPTH-stage delay line. J, JR and BEQZ are resolved in the
//   last stage. A taken branch redirects the pc and kills the wrong-path
//   entries behind it. It also raises squash for 1+SHADOW unstalled cycles and
//   bumps a saturating taken-branch counter.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   stall             freeze delay line and shadow counter
//   dec_valid         decode slot holds a real instruction
//   dec_branch_ctl    00 none, 01 J abs, 10 JR, 11 BEQZ
//   dec_imm, dec_pc   immediate / pc of the decoded instruction
//   res_rs_data       rs value for the resolve-stage entry (JR target)
//   res_zflag         ALU zero flag for the resolve-stage entry (BEQZ)
//   do_branch         redirect pc this cycle
//   branch_target     redirect address, 0 when do_branch=0
//   squash            suppress RF/dmem writes this cycle
//   taken_cnt         taken branches since reset, saturating
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int PC_W   = 9,
  parameter int IMM_W  = 16,
  parameter int DEPTH  = 3,
  parameter int SHADOW = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             dec_valid,
  input  logic [1:0]       dec_branch_ctl,
  input  logic [IMM_W-1:0] dec_imm,
  input  logic [PC_W-1:0]  dec_pc,
  input  logic [PC_W-1:0]  res_rs_data,
  input  logic             res_zflag,
  output logic             do_branch,
  output logic [PC_W-1:0]  branch_target,
  output logic             squash,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0] CTL_J    = 2'b01;
  localparam logic [1:0] CTL_JR   = 2'b10;
  localparam logic [1:0] CTL_BEQZ = 2'b11;

  // Shadow counter must hold SHADOW; keep at least one bit when SHADOW=0.
  localparam int SH_W = (SHADOW < 1) ? 1 : $clog2(SHADOW + 1);

  // Only the low PC_W bits of the immediate ever feed a target, so the
  // delay line carries just those.
  typedef struct packed {
    logic [1:0]      ctl;
    logic [PC_W-1:0] imm;
    logic [PC_W-1:0] pc;
  } br_info_t;

  logic [DEPTH-1:0] vld_pipe;
  br_info_t         info_pipe [DEPTH];
  br_info_t         res;
  logic [SH_W-1:0]  shadow_cnt;
  logic             shadow_active;
  logic             flushin;
  logic             hit;
  logic [PC_W-1:0]  tgt;
  logic             unused_imm_hi;

  assign unused_imm_hi = ^dec_imm;

  assign res           = info_pipe[DEPTH-1];
  assign shadow_active = (shadow_cnt != '0);
  assign flushin       = shadow_active | do_branch;

  // Resolve stage.
  assign hit = vld_pipe[DEPTH-1] &
               ((res.ctl == CTL_J) | (res.ctl == CTL_JR) |
                ((res.ctl == CTL_BEQZ) & res_zflag));

  // A stalled hit stays parked in the resolve stage and fires on the first
  // unstalled cycle, using the res_* inputs present then.
  assign do_branch = hit & ~stall & ~reset;

  always_comb begin
    tgt = '0;
    case (res.ctl)
      CTL_J:    tgt = res.imm;
      CTL_JR:   tgt = res_rs_data;
      CTL_BEQZ: tgt = res.pc + PC_W'(1) + res.imm;  // wraps mod 2^PC_W
      default:  tgt = '0;
    endcase
  end

  assign branch_target = do_branch ? tgt : '0;
  assign squash        = do_branch | shadow_active;

  // Control state: valid bits, shadow counter, taken counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe   <= '0;
      shadow_cnt <= '0;
      taken_cnt  <= '0;
    end else if (!stall) begin
      // Anything decoded during a shadow (or in the redirect cycle itself)
      // is wrong-path, so it enters invalid; a redirect also kills every
      // entry already in flight.
      vld_pipe[0] <= dec_valid & ~flushin;
      for (int k = 1; k < DEPTH; k++)
        vld_pipe[k] <= vld_pipe[k-1] & ~do_branch;

      if (do_branch)
        shadow_cnt <= SH_W'(SHADOW);
      else if (shadow_active)
        shadow_cnt <= shadow_cnt - SH_W'(1);

      if (do_branch && (taken_cnt != '1))
        taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

  // Payload needs no reset: it is qualified by vld_pipe everywhere.
  always_ff @(posedge clk) begin
    if (!stall) begin
      info_pipe[0] <= '{ctl: dec_branch_ctl, imm: dec_imm[PC_W-1:0], pc: dec_pc};
      for (int k = 1; k < DEPTH; k++)
        info_pipe[k] <= info_pipe[k-1];
    end
  end

endmodule
